out_byte_uart_tx: RTL

//  Downstream consumer of the SoC's write-only byte port (out_byte/out_byte_en) and
//  the peripheral that drives the board TX pin. Buffers each strobed byte in a FIFO,

---
 rtl/out_byte_uart_tx_if.sv | 28 ++
 rtl/out_byte_uart_tx.sv | 121 ++++++++++++
 2 files changed

// File: rtl/out_byte_uart_tx_if.sv
// out_byte_uart_tx_if: bundle between the CPU byte port and the UART transmitter.
//   byte_i/byte_en_i  byte strobe from the CPU store path
//   clr_overflow_i    clears the sticky overflow flag
//   txd_o             UART line, idle high
//   busy_o            FIFO non-empty or frame in flight
//   fifo_level_o      bytes currently buffered, 0..2**FIFO_AW
//   overflow_o        sticky: a strobed byte was dropped on a full FIFO
interface out_byte_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       byte_i;
    logic             byte_en_i;
    logic             clr_overflow_i;
    logic             txd_o;
    logic             busy_o;
    logic [FIFO_AW:0] fifo_level_o;
    logic             overflow_o;

    modport slave (
        input  byte_i, byte_en_i, clr_overflow_i,
        output txd_o, busy_o, fifo_level_o, overflow_o
    );

    modport master (
        output byte_i, byte_en_i, clr_overflow_i,
        input  txd_o, busy_o, fifo_level_o, overflow_o
    );
endinterface

// File: rtl/out_byte_uart_tx.sv
// out_byte_uart_tx: FIFO-buffered 8N1/8N2 UART transmitter fed by the CPU byte port.
//   clk_i  system clock, rising edge
//   rst_i  asynchronous active-high reset; aborts any frame and flushes the FIFO
//   bus    out_byte_uart_tx_if.slave (byte strobe in, line and status out)
module out_byte_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4,
    parameter int STOP_BITS    = 1,
    parameter bit INVERT_IN    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    out_byte_uart_tx_if.slave bus
);
    localparam int                DEPTH     = 2 ** FIFO_AW;
    localparam int                BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0]  FULL      = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             r_state, w_state_nxt;
    logic [BW-1:0]      r_baud, w_baud_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_txd, w_txd_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_ovf;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_level, w_level_nxt;
    logic               w_pop, w_full, w_push, w_drop, w_baud_done;
    logic [7:0]         w_wdata;

    assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
    assign w_full      = r_level == FULL;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push      = bus.byte_en_i && (!w_full || w_pop);
    assign w_drop      = bus.byte_en_i && w_full && !w_pop;
    assign w_level_nxt = r_level + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
    assign w_wdata     = INVERT_IN ? ~bus.byte_i : bus.byte_i;
    assign w_baud_done = r_baud == BAUD_LAST;

    // txd is registered from the current state, so the line trails the state by one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_done ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (w_pop) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = r_mem[r_rd_ptr];
                end
            end
            S_START: begin
                w_txd_nxt = 1'b0;
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                w_txd_nxt = r_shift[0];
                if (w_baud_done) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_state_nxt = (r_bit == 3'd7) ? S_STOP : S_DATA;
                    w_bit_nxt   = (r_bit == 3'd7) ? 3'd0 : r_bit + 3'd1;
                end
            end
            default: begin
                // bit_cnt is reused to count stop bits
                if (w_baud_done) begin
                    w_state_nxt = (r_bit == STOP_LAST) ? S_IDLE : S_STOP;
                    w_bit_nxt   = (r_bit == STOP_LAST) ? 3'd0 : r_bit + 3'd1;
                end
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) || (w_level_nxt != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_txd    <= w_txd_nxt;
            r_busy   <= w_busy_nxt;
            r_ovf    <= w_drop ? 1'b1 : (bus.clr_overflow_i ? 1'b0 : r_ovf);
            r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_level  <= w_level_nxt;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wdata;
    end

    assign bus.txd_o        = r_txd;
    assign bus.busy_o       = r_busy;
    assign bus.fifo_level_o = r_level;
    assign bus.overflow_o   = r_ovf;
endmodule
